router_out_drain: RTL

//  Reader side of one router output FIFO: drains bytes from the 16-deep FIFO and presents them to the

---
 rtl/router_pkg.sv | 20 ++
 rtl/router_drain_skid.sv | 61 ++++++
 rtl/router_out_drain.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/router_pkg.sv
// Shared router definitions: header field layout, drain FSM states and the
// default stall timeout. Used by the router FSM, the FIFO and the output drain.
package router_pkg;

  // Header byte: [7:2] payload length (0..63), [1:0] destination address
  localparam int LEN_MSB         = 7;
  localparam int LEN_LSB         = 2;
  localparam int ADDR_W          = 2;
  localparam int LEN_W           = LEN_MSB - LEN_LSB + 1;

  // Consecutive stalled cycles before the FIFO is soft-reset
  localparam int DEFAULT_TIMEOUT = 30;

  typedef enum logic [1:0] {
    HDR = 2'd0,
    PAY = 2'd1,
    PAR = 2'd2
  } drain_state_e;

endpackage

// File: rtl/router_drain_skid.sv
// 2-entry output buffer for the router drain.
// Ports:
//   clock, resetn   clock / async active-low reset
//   flush           drop all entries (wins over push/pop)
//   push, din       write a byte (caller guarantees room)
//   pop             remove head (caller guarantees vld)
//   dout, vld       head byte and its valid
//   count           entries held (0..2)
module router_drain_skid #(
  parameter int DATA_W = 8
) (
  input  logic              clock,
  input  logic              resetn,
  input  logic              flush,
  input  logic              push,
  input  logic [DATA_W-1:0] din,
  input  logic              pop,
  output logic [DATA_W-1:0] dout,
  output logic              vld,
  output logic [1:0]        count
);

  logic [DATA_W-1:0] head, tail;
  logic [1:0]        cnt;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      head <= '0;
      tail <= '0;
      cnt  <= '0;
    end else if (flush) begin
      cnt  <= '0;
    end else begin
      unique case ({push, pop})
        2'b10: begin
          if (cnt == 2'd0) head <= din;
          else             tail <= din;
          cnt <= cnt + 2'd1;
        end
        2'b01: begin
          head <= tail;
          cnt  <= cnt - 2'd1;
        end
        2'b11: begin
          // Count unchanged; the new byte lands behind whatever survives the pop
          if (cnt == 2'd1) head <= din;
          else begin
            head <= tail;
            tail <= din;
          end
        end
        default: ;
      endcase
    end
  end

  assign dout  = head;
  assign vld   = (cnt != 2'd0);
  assign count = cnt;

endmodule

// File: rtl/router_out_drain.sv
// Reader side of one router output FIFO. Pulls bytes from the FIFO into a
// 2-entry buffer, presents them over valid/ready, tracks packet framing
// (header / payload / parity), checks parity and soft-resets the FIFO when
// the destination stalls for TIMEOUT cycles.
// Optional build macro: ROUTER_DRAIN_STATS_EN adds pkt_cnt / err_cnt outputs.
// Ports:
//   clock, resetn         clock / async active-low reset
//   fifo_empty, fifo_data FIFO status and read data (valid 1 cycle after fifo_rd)
//   fifo_rd, soft_reset   FIFO read enable and stall-timeout pulse
//   read_enb              destination ready
//   vld_out, data_out     byte to destination
//   sop, eop              header / parity byte qualifiers
//   parity_err            pulse the cycle after a bad parity byte transfers
//   pkt_cnt, err_cnt      (stats build only) packet and error counters
module router_out_drain
  import router_pkg::*;
#(
  parameter int DATA_W  = 8,
  parameter int TIMEOUT = DEFAULT_TIMEOUT,
  parameter int TMR_W   = 5
) (
  input  logic              clock,
  input  logic              resetn,
  input  logic              fifo_empty,
  input  logic [DATA_W-1:0] fifo_data,
  output logic              fifo_rd,
  output logic              soft_reset,
  input  logic              read_enb,
  output logic              vld_out,
  output logic [DATA_W-1:0] data_out,
  output logic              sop,
  output logic              eop,
`ifdef ROUTER_DRAIN_STATS_EN
  output logic [15:0]       pkt_cnt,
  output logic [7:0]        err_cnt,
`endif
  output logic              parity_err
);

  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);

  drain_state_e      state, nxt;
  logic              in_flight;
  logic [1:0]        count;
  logic [2:0]        occ, room_chk;
  logic              xfer, stall, hit;
  logic [TMR_W-1:0]  timer;
  logic [LEN_W-1:0]  remaining;
  logic [DATA_W-1:0] xor_acc;

  router_drain_skid #(.DATA_W(DATA_W)) u_skid (
    .clock  (clock),
    .resetn (resetn),
    .flush  (hit),
    .push   (in_flight),
    .din    (fifo_data),
    .pop    (xfer),
    .dout   (data_out),
    .vld    (vld_out),
    .count  (count)
  );

  assign xfer  = vld_out & read_enb;
  assign stall = vld_out & ~read_enb;
  assign hit   = stall & (timer == TMR_LAST);

  // Credit: buffered entries plus the read still in flight must leave room
  // after this cycle's pop. resetn gating keeps fifo_rd low while in reset.
  assign occ      = {1'b0, count} + {2'b0, in_flight};
  assign room_chk = occ - {2'b0, xfer};
  assign fifo_rd  = resetn & ~fifo_empty & ~soft_reset & (room_chk < 3'd2);

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      in_flight  <= 1'b0;
      soft_reset <= 1'b0;
      timer      <= '0;
    end else begin
      soft_reset <= hit;
      in_flight  <= fifo_rd & ~hit;   // a read landing on the flush edge is dropped
      timer      <= (hit || !stall) ? '0 : timer + 1'b1;
    end
  end

  // Framing FSM: state register
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn)  state <= HDR;
    else if (hit) state <= HDR;
    else          state <= nxt;
  end

  // Framing FSM: next state, advances on transfers only
  always_comb begin
    nxt = state;
    if (xfer) begin
      unique case (state)
        HDR:     nxt = (data_out[LEN_MSB:LEN_LSB] != '0) ? PAY : PAR;
        PAY:     nxt = (remaining == LEN_W'(1)) ? PAR : PAY;
        PAR:     nxt = HDR;
        default: nxt = HDR;
      endcase
    end
  end

  // Framing FSM: outputs
  always_comb begin
    sop = vld_out & (state == HDR);
    eop = vld_out & (state == PAR);
  end

  // Length / running parity datapath
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      remaining  <= '0;
      xor_acc    <= '0;
      parity_err <= 1'b0;
    end else if (hit) begin
      remaining  <= '0;
      xor_acc    <= '0;
      parity_err <= 1'b0;
    end else begin
      parity_err <= xfer & (state == PAR) & (xor_acc != data_out);
      if (xfer) begin
        unique case (state)
          HDR: begin
            remaining <= data_out[LEN_MSB:LEN_LSB];
            xor_acc   <= data_out;
          end
          PAY: begin
            remaining <= remaining - 1'b1;
            xor_acc   <= xor_acc ^ data_out;
          end
          default: xor_acc <= '0;
        endcase
      end
    end
  end

`ifdef ROUTER_DRAIN_STATS_EN
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      pkt_cnt <= '0;
      err_cnt <= '0;
    end else begin
      if (xfer && eop) pkt_cnt <= pkt_cnt + 16'd1;
      if ((parity_err || soft_reset) && err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
    end
  end
`endif

endmodule
